// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared UART controller definitions: register map, STATUS/CTRL bit positions,
// TX state encoding and the CTRL register layout.
package uart_fifo_ctrl_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int ST_IRQ_RX      = 0;
  localparam int ST_IRQ_TX      = 1;
  localparam int ST_RX_BUSY     = 2;
  localparam int ST_TX_BUSY     = 3;
  localparam int ST_RX_EMPTY    = 4;
  localparam int ST_RX_FULL     = 5;
  localparam int ST_TX_EMPTY    = 6;
  localparam int ST_TX_FULL     = 7;
  localparam int ST_RX_OVERRUN  = 8;
  localparam int ST_TX_OVERFLOW = 9;
  localparam int ST_RX_CNT_LSB  = 16;

  localparam int CT_RX_IE      = 0;
  localparam int CT_TX_IE      = 1;
  localparam int CT_RX_THR_EN  = 2;
  localparam int CT_RX_THR_LSB = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic [7:0] rx_thr;
    logic       rx_thr_en;
    logic       tx_ie;
    logic       rx_ie;
  } ctrl_t;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// CPU-side register bus of the UART FIFO controller: strobes, address, data,
// ready and the combined interrupt line.
interface uart_fifo_ctrl_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_, irq
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_, irq
  );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read port and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO controller: CPU register block (STATUS/DATA/CTRL), RX and TX FIFOs,
// sticky interrupt/error flags and the TX hand-off state machine.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  uart_fifo_ctrl_if.slave  bus,
  input  logic             rx_busy,
  input  logic             rx_end,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  input  logic             tx_end,
  output logic             tx_start,
  output logic [7:0]       tx_data
);

  logic             access, rd_acc, wr_acc;
  logic             status_wr, data_rd, data_wr, ctrl_wr;
  ctrl_t            ctrl;
  logic             irq_rx, irq_tx, rx_overrun, tx_overflow;
  logic             rx_push_ok, rx_pop_ok, rx_empty, rx_full;
  logic [7:0]       rx_rdata;
  logic [CNT_W-1:0] rx_count, rx_post_cnt;
  logic             tx_push_ok, tx_pop, tx_done, tx_empty, tx_full;
  logic [7:0]       tx_rdata;
  logic [CNT_W-1:0] tx_count_unused;
  logic             rx_irq_set, tx_irq_set, rx_ovr_set, tx_ovf_set;
  tx_state_t        tx_state, tx_state_d;
  logic [31:0]      status_word, ctrl_word, rd_mux;
  logic             unused_wr_hi;

  assign access    = !bus.cs_ && !bus.as_;
  assign rd_acc    = access && bus.rw;
  assign wr_acc    = access && !bus.rw;
  assign status_wr = wr_acc && (bus.addr == ADDR_STATUS);
  assign data_rd   = rd_acc && (bus.addr == ADDR_DATA);
  assign data_wr   = wr_acc && (bus.addr == ADDR_DATA);
  assign ctrl_wr   = wr_acc && (bus.addr == ADDR_CTRL);
  assign unused_wr_hi = ^bus.wr_data[31:16];

  // The threshold compares against the occupancy as it will be after this
  // cycle's push and pop have both taken effect.
  assign rx_pop_ok   = data_rd && !rx_empty;
  assign rx_push_ok  = rx_end && (!rx_full || rx_pop_ok);
  assign rx_post_cnt = rx_count + CNT_W'(rx_push_ok) - CNT_W'(rx_pop_ok);
  assign rx_irq_set  = rx_end &&
                       (!ctrl.rx_thr_en || (32'(rx_post_cnt) >= 32'(ctrl.rx_thr)));
  assign rx_ovr_set  = rx_end && rx_full && !rx_pop_ok;

  assign tx_push_ok  = data_wr && (!tx_full || tx_pop);
  assign tx_ovf_set  = data_wr && !tx_push_ok;
  assign tx_irq_set  = tx_done && tx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_ok),
    .pop   (rx_pop_ok),
    .wdata (rx_data),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push_ok),
    .pop   (tx_pop),
    .wdata (bus.wr_data[7:0]),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count_unused)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    status_word                        = '0;
    status_word[ST_IRQ_RX]             = irq_rx;
    status_word[ST_IRQ_TX]             = irq_tx;
    status_word[ST_RX_BUSY]            = rx_busy;
    status_word[ST_TX_BUSY]            = tx_busy;
    status_word[ST_RX_EMPTY]           = rx_empty;
    status_word[ST_RX_FULL]            = rx_full;
    status_word[ST_TX_EMPTY]           = tx_empty;
    status_word[ST_TX_FULL]            = tx_full;
    status_word[ST_RX_OVERRUN]         = rx_overrun;
    status_word[ST_TX_OVERFLOW]        = tx_overflow;
    status_word[ST_RX_CNT_LSB +: 8]    = 8'(rx_count);

    ctrl_word                          = '0;
    ctrl_word[CT_RX_IE]                = ctrl.rx_ie;
    ctrl_word[CT_TX_IE]                = ctrl.tx_ie;
    ctrl_word[CT_RX_THR_EN]            = ctrl.rx_thr_en;
    ctrl_word[CT_RX_THR_LSB +: 8]      = ctrl.rx_thr;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_STATUS: rd_mux = status_word;
      ADDR_DATA:   rd_mux = {24'h0, rx_empty ? 8'h00 : rx_rdata};
      ADDR_CTRL:   rd_mux = ctrl_word;
      ADDR_RSVD:   rd_mux = '0;
      default:     rd_mux = '0;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rd_data <= '0;
      bus.rdy_    <= 1'b1;
      bus.irq     <= 1'b0;
      ctrl        <= '0;
      irq_rx      <= 1'b0;
      irq_tx      <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      bus.rdy_    <= !access;
      bus.rd_data <= rd_acc ? rd_mux : '0;
      bus.irq     <= (irq_rx & ctrl.rx_ie) | (irq_tx & ctrl.tx_ie) |
                     (rx_overrun & ctrl.rx_ie);
      if (ctrl_wr) begin
        ctrl.rx_ie     <= bus.wr_data[CT_RX_IE];
        ctrl.tx_ie     <= bus.wr_data[CT_TX_IE];
        ctrl.rx_thr_en <= bus.wr_data[CT_RX_THR_EN];
        ctrl.rx_thr    <= bus.wr_data[CT_RX_THR_LSB +: 8];
      end
      irq_rx      <= rx_irq_set | (irq_rx & !(status_wr && bus.wr_data[ST_IRQ_RX]));
      irq_tx      <= tx_irq_set | (irq_tx & !(status_wr && bus.wr_data[ST_IRQ_TX]));
      rx_overrun  <= rx_ovr_set |
                     (rx_overrun & !(status_wr && bus.wr_data[ST_RX_OVERRUN]));
      tx_overflow <= tx_ovf_set |
                     (tx_overflow & !(status_wr && bus.wr_data[ST_TX_OVERFLOW]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state;
    case (tx_state)
      TX_IDLE: if (!tx_empty && !tx_busy) tx_state_d = TX_WAIT;
      TX_WAIT: if (tx_end)                tx_state_d = TX_IDLE;
      default:                            tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    tx_done = 1'b0;
    case (tx_state)
      TX_IDLE: tx_pop  = !tx_empty && !tx_busy;
      TX_WAIT: tx_done = tx_end;
      default: ;
    endcase
  end

  // tx_start is registered off the IDLE pop; the FSM then spends at least one
  // cycle in WAIT, so two starts can never be adjacent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= tx_pop;
      if (tx_pop) tx_data <= tx_rdata;
    end
  end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX and TX FIFO entries; power of two, 2..256.
REQ-002 Parameter CNT_W, default 5, FIFO occupancy counter width, equal to log2(FIFO_DEPTH)+1.
REQ-003 Ports SHALL be:
  clk  in  1  clock
  reset  in  1  reset; one clock; reset is synchronous and active-low
  cs_  in  1  chip select, active-low
  as_  in  1  address strobe, active-low
  rw  in  1  1=read, 0=write
  addr  in  2  register select
  wr_data  in  32  write data
  rd_data  out  32  read data
  rdy_  out  1  ready, active-low
  irq  out  1  combined masked interrupt
  rx_busy  in  1  receiver busy
  rx_end  in  1  one-cycle received-byte strobe
  rx_data  in  8  received byte, valid with rx_end
  tx_busy  in  1  transmitter busy
  tx_end  in  1  one-cycle transmit-complete strobe
  tx_start  out  1  one-cycle transmit request
  tx_data  out  8  byte to transmit

Function
REQ-004 An access is cs_=0 and as_=0; rdy_ SHALL go 0 the cycle after each access cycle and 1 otherwise.
REQ-005 rd_data SHALL be registered: the read value appears the cycle after the access, and is 0 in every cycle after a non-read cycle.
REQ-006 addr 0 STATUS (read): [0] irq_rx, [1] irq_tx, [2] rx_busy, [3] tx_busy, [4] rx_empty, [5] rx_full, [6] tx_empty, [7] tx_full, [8] rx_overrun, [9] tx_overflow, [23:16] rx_count zero-extended, other bits 0.
REQ-007 STATUS write: write-1-to-clear on bits [0],[1],[8],[9]; writing 0 leaves the bit unchanged.
REQ-008 addr 1 DATA read: returns the RX head byte in [7:0] and pops the RX FIFO; if the RX FIFO is empty it returns 0 and does not pop.
REQ-009 DATA write: pushes wr_data[7:0] into the TX FIFO; if the TX FIFO is full the byte is dropped and tx_overflow is set.
REQ-010 addr 2 CTRL (read/write): [0] rx_ie, [1] tx_ie, [2] rx_thr_en; [15:8] rx_thr. Unused bits read 0.
REQ-011 addr 3 is reserved: reads return 0 and writes are ignored.
REQ-012 rx_end SHALL push rx_data into the RX FIFO and set irq_rx. When rx_thr_en=1, irq_rx is set only when the post-push count is >= rx_thr.
REQ-013 If the RX FIFO is full, rx_end arrives, and no pop happens in the same cycle, the byte is dropped and rx_overrun is set. A simultaneous pop and push on a full FIFO SHALL both succeed.
REQ-014 If a W1C clear and a set event for the same bit occur in the same cycle, the set SHALL win.
REQ-015 TX FSM, state TX_IDLE: if the TX FIFO is non-empty and tx_busy=0, pop the head into tx_data, pulse tx_start for 1 cycle, then go to TX_WAIT.
REQ-016 TX FSM, state TX_WAIT: tx_data is held; on tx_end go to TX_IDLE, and set irq_tx if the TX FIFO is empty in that cycle.
REQ-017 tx_start SHALL never be asserted in two consecutive cycles. A CPU push and an FSM pop in the same cycle SHALL both succeed.
REQ-018 irq SHALL be registered and equal (irq_rx & rx_ie) | (irq_tx & tx_ie) | (rx_overrun & rx_ie), delayed by one cycle.
REQ-019 Occupancy counters SHALL be CNT_W bits wide. Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-020 When reset=0 at a clk edge, the block SHALL set: rd_data=0, rdy_=1, irq=0, tx_start=0, tx_data=0, CTRL=0, all sticky bits=0, both FIFOs empty, TX FSM=TX_IDLE.
REQ-021 Reset in mid-transfer SHALL abandon TX_WAIT and discard all FIFO contents; FIFO data RAM needs no reset.

Structure
REQ-022 Register addresses, STATUS/CTRL bit positions, and TX FSM state encodings SHALL live in the shared uart header.
REQ-023 A sub-module uart_fifo (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, empty, full, count) SHALL be instantiated once for RX and once for TX.

Verification
REQ-024 The bench SHALL cover these scenarios:
  - Reset, then read STATUS -> rd_data=0x00000050 (rx_empty, tx_empty).
  - Write DATA 0x41, 0x42 with tx_busy held 0 -> tx_start pulses with tx_data 0x41. After tx_end, it pulses with 0x42. After the second tx_end, irq_tx=1; with tx_ie=1, irq=1 one cycle later.
  - 17 rx_end strobes (0x00..0x10) with FIFO_DEPTH=16 -> rx_full=1, rx_overrun=1, rx_count=16. 16 DATA reads return 0x00..0x0F; a 17th read returns 0.
  - CTRL=0x0305 (rx_thr=3, rx_thr_en, rx_ie); push 2 bytes -> irq_rx=0; push a 3rd byte -> irq_rx=1.
  - W1C write of 0x1 to STATUS in the same cycle as rx_end -> irq_rx remains 1.
  - Assert reset during TX_WAIT with 4 bytes queued -> tx_start=0, tx_empty=1; no further tx_start after reset is released.
